div_pipe: RTL
=============

// Module: div_pipe
// PURPOSE
//  Fully pipelined integer divider: accepts one quotient/remainder request per clock and
//  returns results in order after a fixed latency. Replaces the free-running divider with
//  a valid/ready handshake, pipeline-wide stall and defined divide-by-zero results.
//  Optional signed mode. Sits between a stream producer and a stream consumer.
// PARAMETERS
//  DATA_W   32   operand/result width in bits (>=2)
//  LAT      DATA_W+2   derived localparam: pipeline depth in cycles (not overridable)
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       synchronous active-high reset
//  in_valid     in   1       request present on dividend/divisor
//  in_ready     out  1       divider can accept a request this cycle
//  dividend     in   DATA_W  dividend operand
//  divisor      in   DATA_W  divisor operand
//  in_signed    in   1       treat operands as two's complement (only with DIV_SIGNED_EN)
//  out_valid    out  1       quotient/remainder/dbz valid
//  out_ready    in   1       consumer accepts result this cycle
//  quotient     out  DATA_W  result quotient
//  remainder    out  DATA_W  result remainder
//  dbz          out  1       request had divisor == 0
// BEHAVIOUR
//  - Reset: all stage valid bits clear; out_valid=0, quotient=0, remainder=0, dbz=0;
//    in_ready=1 in the cycle after rst deasserts. rst mid-operation discards every in-flight op.
//  - Accept: transfer when in_valid && in_ready on rising edge. Deliver: out_valid && out_ready.
//  - Stall: stall = out_valid && !out_ready; in_ready = !stall (combinational, no in->out path
//    other than out_ready->in_ready). On stall every stage holds, outputs stay stable.
//  - Bubbles allowed: stage valid bits propagate 0 when no request accepted.
//  - Latency: with no stall, request accepted at edge k -> out_valid=1 after edge k+LAT.
//    Throughput 1 op/cycle; results strictly in acceptance order.
//  - Stage 0 (pre): register operands, dbz=(divisor==0); signed mode: take magnitudes,
//    record q_neg = sign(dividend)^sign(divisor), r_neg = sign(dividend).
//  - Stages 1..DATA_W: one restoring-division step each, MSB first; partial remainder
//    DATA_W+1 bits; subtract if partial >= divisor, shift quotient bit in.
//  - Stage DATA_W+1 (post): apply sign correction, zero-divisor override, register outputs.
//  - Divisor 0: quotient = all ones, remainder = dividend (original, unsigned/signed), dbz=1.
//  - Signed overflow (dividend = -2^(DATA_W-1), divisor = -1): quotient = -2^(DATA_W-1),
//    remainder = 0, dbz=0. Falls out of magnitude arithmetic; no special path needed beyond
//    truncation to DATA_W bits.
//  - Signed results truncate toward zero; remainder takes dividend's sign.
//  - Unsigned: quotient = dividend / divisor, remainder = dividend % divisor exactly.
// CONFIGURATION
//  DIV_SIGNED_EN defined: in_signed port present; in_signed=1 selects signed op per request,
//    in_signed=0 unsigned. Sign flags carried down the pipeline with each op.
//  DIV_SIGNED_EN undefined: in_signed port absent; all ops unsigned; sign logic removed;
//    LAT unchanged (DATA_W+2).
// TESTING (DATA_W=32, LAT=34)
//  1 Single op 100/7, out_ready=1 -> after 34 edges quotient=14, remainder=2, dbz=0, one pulse.
//  2 5/0 -> quotient=32'hFFFFFFFF, remainder=5, dbz=1; next op 9/3 -> 3, 0, dbz=0.
//  3 100 random ops back-to-back, out_ready=1 -> 100 results in order, each matches / and %,
//    in_ready never drops; random in_valid gaps -> same matches, bubbles not emitted.
//  4 Stream running, out_ready=0 for 5 cycles -> in_ready=0, outputs frozen 5 cycles,
//    no op lost or duplicated after release.
//  5 DIV_SIGNED_EN, in_signed=1: -7/2 -> q=32'hFFFFFFFD, r=32'hFFFFFFFF;
//    32'h80000000/32'hFFFFFFFF -> q=32'h80000000, r=0; in_signed=0 on 32'hFFFFFFF9/2 ->
//    q=32'h7FFFFFFC, r=1.
//  6 rst pulsed with 10 ops in flight -> out_valid=0 next cycle, none of the 10 emitted;
//    new op 20/6 after reset -> q=3, r=2 after 34 edges.

Source files
------------

// File: rtl/div_if.sv
// Request/result stream bundle for div_pipe. The in_signed lane exists only when
// DIV_SIGNED_EN is defined.
interface div_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic              in_signed;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              dbz;

    modport slave (
`ifdef DIV_SIGNED_EN
        input  in_signed,
`endif
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz
    );

    modport master (
`ifdef DIV_SIGNED_EN
        output in_signed,
`endif
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz
    );
endinterface

// File: rtl/div_pipe.sv
// Fully pipelined restoring divider with valid/ready stall and defined divide-by-zero.
// Define DIV_SIGNED_EN to add per-request two's complement operation.
module div_pipe #(
    parameter int DATA_W = 32
) (
    input logic   clk,
    input logic   rst,
    div_if.slave  bus
);
    localparam int W   = DATA_W;
    localparam int LAT = DATA_W + 2;

    // vld_q[0] = pre stage, [1..W] = division steps, [W+1] = post, [LAT] = output
    logic [LAT:0] vld_q;
    logic         stall;
    logic         adv;

    assign stall        = vld_q[LAT] && !bus.out_ready;
    assign adv          = !stall;
    assign bus.in_ready = adv;

    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic         dbz_d;

    assign dbz_d = (bus.divisor == '0);

`ifdef DIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic qneg_q [0:W];
    logic rneg_q [0:W];

    assign a_neg = bus.in_signed & bus.dividend[W-1];
    assign b_neg = bus.in_signed & bus.divisor[W-1];
    assign a_mag = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag = b_neg ? -bus.divisor  : bus.divisor;
`else
    assign a_mag = bus.dividend;
    assign b_mag = bus.divisor;
`endif

    // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom
    logic [W-1:0] rem_q [0:W];
    logic [W-1:0] quo_q [0:W];
    logic [W-1:0] den_q [0:W-1];
    logic         dbz_q [0:W];
    logic [W-1:0] rem_d [1:W];
    logic [W-1:0] quo_d [1:W];

    generate
        for (genvar gi = 1; gi <= W; gi++) begin : g_step
            logic [W:0] shifted;
            logic       ge;

            assign shifted   = {rem_q[gi-1], quo_q[gi-1][W-1]};
            assign ge        = (shifted >= {1'b0, den_q[gi-1]});
            // true difference is below the divisor, so W-bit wraparound is exact
            assign rem_d[gi] = ge ? (shifted[W-1:0] - den_q[gi-1]) : shifted[W-1:0];
            assign quo_d[gi] = {quo_q[gi-1][W-2:0], ge};
        end
    endgenerate

    logic [W-1:0] q_fix;
    logic [W-1:0] r_fix;

`ifdef DIV_SIGNED_EN
    assign q_fix = qneg_q[W] ? -quo_q[W] : quo_q[W];
    assign r_fix = rneg_q[W] ? -rem_q[W] : rem_q[W];
`else
    assign q_fix = quo_q[W];
    assign r_fix = rem_q[W];
`endif

    logic [W-1:0] post_quo_q;
    logic [W-1:0] post_rem_q;
    logic         post_dbz_q;

    // A zero divisor leaves the dividend magnitude in the remainder path, so only
    // the quotient needs overriding.
    always_ff @(posedge clk) begin : data_pipe
        if (adv) begin
            rem_q[0] <= '0;
            quo_q[0] <= a_mag;
            den_q[0] <= b_mag;
            dbz_q[0] <= dbz_d;
`ifdef DIV_SIGNED_EN
            qneg_q[0] <= a_neg ^ b_neg;
            rneg_q[0] <= a_neg;
            for (int i = 1; i <= W; i++) begin
                qneg_q[i] <= qneg_q[i-1];
                rneg_q[i] <= rneg_q[i-1];
            end
`endif
            for (int i = 1; i <= W; i++) begin
                rem_q[i] <= rem_d[i];
                quo_q[i] <= quo_d[i];
                dbz_q[i] <= dbz_q[i-1];
            end
            for (int i = 1; i < W; i++) begin
                den_q[i] <= den_q[i-1];
            end
            post_quo_q <= dbz_q[W] ? '1 : q_fix;
            post_rem_q <= r_fix;
            post_dbz_q <= dbz_q[W];
        end
    end

    logic [W-1:0] quo_out_q;
    logic [W-1:0] rem_out_q;
    logic         dbz_out_q;

    always_ff @(posedge clk) begin : ctrl_pipe
        if (rst) begin
            vld_q     <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_out_q <= 1'b0;
        end else if (adv) begin
            vld_q     <= {vld_q[LAT-1:0], bus.in_valid};
            quo_out_q <= post_quo_q;
            rem_out_q <= post_rem_q;
            dbz_out_q <= post_dbz_q;
        end
    end

    assign bus.out_valid = vld_q[LAT];
    assign bus.quotient  = quo_out_q;
    assign bus.remainder = rem_out_q;
    assign bus.dbz       = dbz_out_q;
endmodule
